// File: rtl/maj_vote_filter_if.sv
// Bundle for maj_vote_filter: sample strobe/data/mask in, voted word and fault status out.
// No internal storage; the master drives the inputs and the slave drives the outputs.
// No backpressure: one sample per cycle; MAJ_VOTE_STICKY_FAULT_EN adds fault_sticky.
interface maj_vote_filter_if #(
    parameter int N     = 3,
    parameter int W     = 1,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     ch_mask;
    logic             clr_cnt;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [N-1:0]     disagree;
    logic             no_quorum;
    logic [CNT_W-1:0] fault_cnt;
`ifdef MAJ_VOTE_STICKY_FAULT_EN
    logic [N-1:0]     fault_sticky;

    modport master (
        output in_valid, in_data, ch_mask, clr_cnt,
        input  out_valid, out_data, disagree, no_quorum, fault_cnt, fault_sticky
    );
    modport slave (
        input  in_valid, in_data, ch_mask, clr_cnt,
        output out_valid, out_data, disagree, no_quorum, fault_cnt, fault_sticky
    );
`else
    modport master (
        output in_valid, in_data, ch_mask, clr_cnt,
        input  out_valid, out_data, disagree, no_quorum, fault_cnt
    );
    modport slave (
        input  in_valid, in_data, ch_mask, clr_cnt,
        output out_valid, out_data, disagree, no_quorum, fault_cnt
    );
`endif
endinterface

// File: rtl/maj_vote_filter.sv
// Bitwise N-channel majority voter with HOLD-sample debounce and fault counter; MAJ_VOTE_STICKY_FAULT_EN adds sticky flags.
// Latency: out_valid two cycles after in_valid, full throughput.
// No backpressure: every in_valid sample is accepted and produces exactly one out_valid.
module maj_vote_filter #(
    parameter int N     = 3,
    parameter int W     = 1,
    parameter int HOLD  = 2,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    maj_vote_filter_if.slave bus
);
    localparam int SW = $clog2(HOLD + 1);
    localparam int CW = $clog2(N + 1) + 1;
    localparam logic [SW-1:0]    HOLD_V  = SW'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             v1;
    logic [N*W-1:0]   data1;
    logic [N-1:0]     mask1;

    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [N-1:0]     disagree;
    logic             no_quorum;
    logic [CNT_W-1:0] fault_cnt;
    logic [W-1:0]     last_raw;
    logic [SW-1:0]    stab_cnt;

    logic [CW-1:0]    ena_cnt;
    logic [CW-1:0]    ones;
    logic [W-1:0]     raw;
    logic [N-1:0]     dis;
    logic [SW-1:0]    stab_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1    <= 1'b0;
            data1 <= '0;
            mask1 <= '0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                data1 <= bus.in_data;
                mask1 <= bus.ch_mask;
            end
        end
    end

    // Ties (including no enabled channel) keep the currently published bit.
    always_comb begin
        ena_cnt = '0;
        ones    = '0;
        raw     = '0;
        dis     = '0;
        for (int k = 0; k < N; k++) ena_cnt = ena_cnt + CW'(mask1[k]);
        for (int i = 0; i < W; i++) begin
            ones = '0;
            for (int k = 0; k < N; k++) ones = ones + CW'(mask1[k] & data1[k*W+i]);
            if ({ones, 1'b0} > {1'b0, ena_cnt})      raw[i] = 1'b1;
            else if ({ones, 1'b0} < {1'b0, ena_cnt}) raw[i] = 1'b0;
            else                                     raw[i] = out_data[i];
        end
        for (int k = 0; k < N; k++) dis[k] = mask1[k] && (data1[k*W +: W] != raw);
    end

    always_comb begin
        stab_nxt = SW'(1);
        if (raw == last_raw) stab_nxt = (stab_cnt == HOLD_V) ? stab_cnt : stab_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            disagree  <= '0;
            no_quorum <= 1'b0;
            fault_cnt <= '0;
            last_raw  <= '0;
            stab_cnt  <= '0;
        end else begin
            out_valid <= v1;
            disagree  <= v1 ? dis : '0;
            no_quorum <= v1 && (ena_cnt == '0);
            if (v1) begin
                last_raw <= raw;
                stab_cnt <= stab_nxt;
                if (stab_nxt == HOLD_V) out_data <= raw;
            end
            if (bus.clr_cnt)
                fault_cnt <= '0;
            else if (v1 && (|dis) && (fault_cnt != CNT_MAX))
                fault_cnt <= fault_cnt + 1'b1;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.disagree  = disagree;
    assign bus.no_quorum = no_quorum;
    assign bus.fault_cnt = fault_cnt;

`ifdef MAJ_VOTE_STICKY_FAULT_EN
    logic [N-1:0] fault_sticky;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       fault_sticky <= '0;
        else if (bus.clr_cnt) fault_sticky <= '0;
        else if (v1)        fault_sticky <= fault_sticky | dis;
    end

    assign bus.fault_sticky = fault_sticky;
`endif
endmodule
